conf_int_mul_pipe_apx: RTL
==========================

CONF_INT_MUL_PIPE_APX -- requirements
Module: conf_int_mul_pipe_apx

Interface
REQ-001 Parameter DATA_PATH_BITWIDTH, default 16: operand width W.
REQ-002 Parameter APX_STEP, default 4: LSBs truncated per approximation level.
REQ-003 Parameter NUM_APX_LVL, default 4: number of levels; level 0 is accurate.
REQ-004 Port list SHALL be as follows; one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_valid  in  1  operand pair valid.
REQ-008 in_ready  out  1  block accepts operands this cycle.
REQ-009 a, b  in  W each  operands.
REQ-010 apx_lvl  in  clog2(NUM_APX_LVL)  approximation level, sampled with the operands.
REQ-011 is_signed  in  1  1 = two's-complement, 0 = unsigned; sampled with the operands.
REQ-012 flush  in  1  synchronous pipeline clear.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  downstream accepts the result.
REQ-015 d  out  2W  product.
REQ-016 out_lvl  out  clog2(NUM_APX_LVL)  level used for d.

Function
REQ-017 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-018 Three register stages: S1 operand truncation, S2 multiply, S3 realign/output; no-stall latency is 3 cycles from accept to out_valid.
REQ-019 adv = !out_valid || out_ready; all stages advance only when adv=1; in_ready = adv && !flush.
REQ-020 Each stage carries valid, level and sign bits; bubbles are not compressed.
REQ-021 Level k: s = k*APX_STEP; a_t = a >> s and b_t = b >> s (arithmetic shift if is_signed, else logical); p = a_t*b_t (signed or unsigned per is_signed); d = p << 2s, sign- or zero-extended to 2W; the 2s LSBs of d are zero.
REQ-022 Level 0: d is the exact 2W-bit product.
REQ-023 apx_lvl >= NUM_APX_LVL clamps to NUM_APX_LVL-1 at S1 capture.
REQ-024 Level, sign mode and apx_lvl are per-transaction; a mid-stream change affects only operands accepted afterwards.
REQ-025 d and out_lvl SHALL be held stable while out_valid && !out_ready.
REQ-026 flush=1: all stage valids clear on the next edge; an in-flight or presented transaction is dropped; flush overrides in_valid and out_ready.
REQ-027 With out_ready held at 1, throughput is one result per cycle.

Reset
REQ-028 While rst=1: all stage valids = 0, out_valid = 0, d = 0, out_lvl = 0, and in_ready follows REQ-019.
REQ-029 Reset asserted mid-operation discards all in-flight transactions; the first transaction accepted after release completes in 3 cycles.

Configuration
REQ-030 Macro CONF_INT_MUL_OPCNT_EN is defined: the block adds output apx_cnt [31:0] and output acc_cnt [31:0], saturating counters of completed level>0 and level-0 output transfers; both clear on rst and on flush.
REQ-031 Macro CONF_INT_MUL_OPCNT_EN is undefined: the counter ports and logic are absent; all other behaviour is identical.

Structure
REQ-032 Package conf_int_mul_pkg holds the per-stage record typedef (valid, lvl, signed, data), lvl width function, and the zero-result constant.
REQ-033 Elaboration check: (NUM_APX_LVL-1)*APX_STEP < W.
REQ-034 The S2 multiplier is sub-module conf_int_mul_core; it is combinational, has a sign-mode input, and has width W.

Verification (W=16, APX_STEP=4, NUM_APX_LVL=4)
REQ-035 a=0x0123, b=0x0010, lvl0, unsigned -> d=0x00001230, out_lvl=0, 3 cycles after accept.
REQ-036 Same operands at lvl1 -> d=0x00001200; at lvl5 -> clamps to lvl3 -> d=0x00000000.
REQ-037 a=0xFFFF, b=0x0002, lvl0: signed -> d=0xFFFFFFFE; unsigned -> d=0x0001FFFE; signed lvl1 -> d=0x00000000.
REQ-038 Back-to-back stream of 8 pairs with out_ready toggling 1/0 -> all 8 results in order; d is held stable while stalled; in_ready is low whenever out_valid && !out_ready.
REQ-039 Two transactions in flight, then flush for 1 cycle -> neither appears on the output; the next accepted pair completes in 3 cycles; counters read 0 (if CONF_INT_MUL_OPCNT_EN is defined).
REQ-040 rst pulse mid-stream -> out_valid=0 and d=0 immediately (asynchronously); no stale result appears after release.

Source files
------------

// File: rtl/conf_int_mul_pkg.sv
// Shared types and helpers for the approximate pipelined integer multiplier.
package conf_int_mul_pkg;

   // Upper bounds that size the shared per-stage record.
   localparam int unsigned MAX_W     = 64;
   localparam int unsigned LVL_MAX_W = 8;

   // Per-stage record: valid, approximation level, sign mode and a data field wide enough for 2W.
   typedef struct packed {
      logic                   valid;
      logic [LVL_MAX_W-1:0]   lvl;
      logic                   sgn;
      logic [2*MAX_W-1:0]     data;
   } stage_t;

   localparam logic [2*MAX_W-1:0] ZERO_RESULT = '0;

   localparam stage_t STAGE_IDLE = '{valid: 1'b0, lvl: '0, sgn: 1'b0, data: ZERO_RESULT};

   // Width of the level field for a given number of levels (never below one bit).
   function automatic int unsigned lvl_w(input int unsigned n);
      return (n <= 1) ? 32'd1 : 32'($clog2(n));
   endfunction

endpackage

// File: rtl/conf_int_mul_pipe_apx_core.sv
// Combinational W x W multiplier with selectable two's-complement or unsigned operands.
module conf_int_mul_core #(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   input  logic           i_is_signed,
   output logic [2*W-1:0] o_p_c
);

   logic [2*W-1:0] w_a_ext;
   logic [2*W-1:0] w_b_ext;

   // Extend both operands to 2W so one unsigned multiply yields the correct low 2W bits in either mode.
   always_comb begin
      if (i_is_signed) begin
         w_a_ext = {{W{i_a[W-1]}}, i_a};
         w_b_ext = {{W{i_b[W-1]}}, i_b};
      end else begin
         w_a_ext = {{W{1'b0}}, i_a};
         w_b_ext = {{W{1'b0}}, i_b};
      end
   end

   assign o_p_c = w_a_ext * w_b_ext;

endmodule

// File: rtl/conf_int_mul_pipe_apx.sv
// Three-stage approximate integer multiplier: S1 truncates operands, S2 multiplies, S3 realigns.
// Optional macro CONF_INT_MUL_OPCNT_EN adds saturating apx_cnt/acc_cnt completion counters.
module conf_int_mul_pipe_apx
   import conf_int_mul_pkg::*;
#(
   parameter int unsigned DATA_PATH_BITWIDTH = 16,
   parameter int unsigned APX_STEP           = 4,
   parameter int unsigned NUM_APX_LVL        = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [DATA_PATH_BITWIDTH-1:0]       a,
   input  logic [DATA_PATH_BITWIDTH-1:0]       b,
   input  logic [lvl_w(NUM_APX_LVL)-1:0]       apx_lvl,
   input  logic                                is_signed,
   input  logic                                flush,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [2*DATA_PATH_BITWIDTH-1:0]     d,
   output logic [lvl_w(NUM_APX_LVL)-1:0]       out_lvl
`ifdef CONF_INT_MUL_OPCNT_EN
   ,
   output logic [31:0]                         apx_cnt,
   output logic [31:0]                         acc_cnt
`endif
);

   localparam int unsigned W  = DATA_PATH_BITWIDTH;
   localparam int unsigned LW = lvl_w(NUM_APX_LVL);
   localparam int unsigned SW = $clog2(2 * W) + 1;

   // Parameter sanity checks at elaboration.
   if (NUM_APX_LVL < 1) begin : g_bad_nlvl
      $error("NUM_APX_LVL must be at least 1");
   end
   if ((NUM_APX_LVL - 1) * APX_STEP >= W) begin : g_bad_step
      $error("(NUM_APX_LVL-1)*APX_STEP must be smaller than DATA_PATH_BITWIDTH");
   end
   if (W > MAX_W) begin : g_bad_width
      $error("DATA_PATH_BITWIDTH exceeds the stage record capacity");
   end
   if (LW > LVL_MAX_W) begin : g_bad_lvlw
      $error("level field exceeds the stage record capacity");
   end

   stage_t            r_s1;
   stage_t            r_s2;
   logic              r_s3_valid;
   logic [LW-1:0]     r_s3_lvl;
   logic [2*W-1:0]    r_s3_d;

   logic              w_adv;
   logic [LW-1:0]     w_lvl_clamped;
   logic [SW-1:0]     w_s1_shift;
   logic [W-1:0]      w_a_t;
   logic [W-1:0]      w_b_t;
   logic [2*W-1:0]    w_s2_ops;
   logic [2*W-1:0]    w_s2_p;
   logic [2*W-1:0]    w_s3_p;
   logic [SW-1:0]     w_s3_shift;
   logic [2*W-1:0]    w_s3_d;

   // The whole pipe moves together; an unconsumed result freezes every stage.
   assign w_adv    = !r_s3_valid || out_ready;
   assign in_ready = w_adv && !flush;

   // Out-of-range levels saturate to the coarsest level.
   always_comb begin
      w_lvl_clamped = apx_lvl;
      if (32'(apx_lvl) >= NUM_APX_LVL) begin
         w_lvl_clamped = LW'(NUM_APX_LVL - 1);
      end
      w_s1_shift = SW'(32'(w_lvl_clamped) * APX_STEP);
   end

   // Drop the low bits of each operand, keeping the sign when operating in two's complement.
   always_comb begin
      if (is_signed) begin
         w_a_t = $signed(a) >>> w_s1_shift;
         w_b_t = $signed(b) >>> w_s1_shift;
      end else begin
         w_a_t = a >> w_s1_shift;
         w_b_t = b >> w_s1_shift;
      end
   end

   // S1 register: truncated operand pair plus its level and sign mode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= STAGE_IDLE;
      end else if (flush) begin
         r_s1.valid <= 1'b0;
      end else if (w_adv) begin
         r_s1.valid <= in_valid;
         if (in_valid) begin
            r_s1.lvl  <= LVL_MAX_W'(w_lvl_clamped);
            r_s1.sgn  <= is_signed;
            r_s1.data <= (2*MAX_W)'({w_a_t, w_b_t});
         end
      end
   end

   assign w_s2_ops = (2*W)'(r_s1.data);

   conf_int_mul_core #(
      .W (W)
   ) u_core (
      .i_a         (w_s2_ops[2*W-1:W]),
      .i_b         (w_s2_ops[W-1:0]),
      .i_is_signed (r_s1.sgn),
      .o_p_c       (w_s2_p)
   );

   // S2 register: raw product of the truncated operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2 <= STAGE_IDLE;
      end else if (flush) begin
         r_s2.valid <= 1'b0;
      end else if (w_adv) begin
         r_s2.valid <= r_s1.valid;
         if (r_s1.valid) begin
            r_s2.lvl  <= r_s1.lvl;
            r_s2.sgn  <= r_s1.sgn;
            r_s2.data <= (2*MAX_W)'(w_s2_p);
         end
      end
   end

   // Shift the product back to full scale; the vacated 2s LSBs are zero.
   always_comb begin
      w_s3_p     = (2*W)'(r_s2.data);
      w_s3_shift = SW'(32'(r_s2.lvl) * APX_STEP * 2);
      if (r_s2.sgn) begin
         w_s3_d = $signed(w_s3_p) <<< w_s3_shift;
      end else begin
         w_s3_d = w_s3_p << w_s3_shift;
      end
   end

   // S3 register: presented result; only what leaves the block is kept here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s3_valid <= 1'b0;
         r_s3_lvl   <= '0;
         r_s3_d     <= (2*W)'(ZERO_RESULT);
      end else if (flush) begin
         r_s3_valid <= 1'b0;
      end else if (w_adv) begin
         r_s3_valid <= r_s2.valid;
         if (r_s2.valid) begin
            r_s3_lvl <= LW'(r_s2.lvl);
            r_s3_d   <= w_s3_d;
         end
      end
   end

   assign out_valid = r_s3_valid;
   assign d         = r_s3_d;
   assign out_lvl   = r_s3_lvl;

`ifdef CONF_INT_MUL_OPCNT_EN
   logic [31:0] r_apx_cnt;
   logic [31:0] r_acc_cnt;

   // Saturating counts of completed approximate and exact output transfers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_apx_cnt <= '0;
         r_acc_cnt <= '0;
      end else if (flush) begin
         r_apx_cnt <= '0;
         r_acc_cnt <= '0;
      end else if (r_s3_valid && out_ready) begin
         if (r_s3_lvl != '0) begin
            if (r_apx_cnt != '1) r_apx_cnt <= r_apx_cnt + 32'd1;
         end else begin
            if (r_acc_cnt != '1) r_acc_cnt <= r_acc_cnt + 32'd1;
         end
      end
   end

   assign apx_cnt = r_apx_cnt;
   assign acc_cnt = r_acc_cnt;
`endif

endmodule
